inst_fetch_unit: RTL and testbench
==================================

# inst_fetch_unit

Instruction fetch unit for the single-cycle-decode NPC core: producer side of the 32-bit `inst` bus consumed by `control_unit`. Holds the PC, issues one instruction-memory read at a time, buffers the returned word and presents it with its PC to decode under a valid/ready handshake. Handles PC redirects from execute and stops fetching on an ebreak-driven halt.

## Interface
Parameters:
- `RESET_PC`, 32'h8000_0000: first fetch address after reset.
- `NOP_INST`, 32'h0000_0013: value on `inst` when nothing is buffered (`addi x0,x0,0`).

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `imem_req`  out  1  read request to instruction memory.
- `imem_addr`  out  32  word-aligned read address.
- `imem_gnt`  in  1  memory accepted the request this cycle.
- `imem_rvalid`  in  1  read data valid.
- `imem_rdata`  in  32  read data.
- `inst`  out  32  buffered instruction to decode.
- `inst_pc`  out  32  PC of `inst`.
- `inst_valid`  out  1  `inst`/`inst_pc` are valid.
- `inst_ready`  in  1  decode accepts this cycle.
- `redirect`  in  1  one-cycle pulse: next fetch from `redirect_pc`.
- `redirect_pc`  in  32  target; bits [1:0] ignored (forced 00).
- `halt`  in  1  one-cycle pulse from ebreak execution.
- `halted`  out  1  fetch stopped.

## Operation
- Registers: `pc`, `inst_buf`, `pc_buf`, `drop` flag, `halt_pend` flag, 2-bit state.
- States: FETCH, WAIT, HOLD, HALT. Reset state FETCH, `pc`=RESET_PC.
- FETCH: `imem_req`=1, `imem_addr`=`pc`. On `imem_gnt` -> WAIT.
- WAIT: `imem_req`=0. On `imem_rvalid`: if `drop` -> discard, clear `drop`, go FETCH (or HALT if `halt_pend`); else `inst_buf`<=`imem_rdata`, `pc_buf`<=`pc`, `pc`<=`pc`+4, -> HOLD.
- HOLD: `inst_valid`=1. On `inst_ready` -> FETCH (HALT if `halt_pend`).
- HALT: no requests, `halted`=1; left only by reset.
- Redirect (`pc`<=`redirect_pc` & ~3):
  - FETCH without gnt: new address used next cycle.
  - FETCH with gnt same cycle: -> WAIT with `drop`=1 (old-address request is in flight).
  - WAIT: set `drop`; same-cycle `imem_rvalid` is itself discarded -> FETCH.
  - HOLD: buffer discarded, `inst_valid` drops next cycle, -> FETCH; simultaneous `inst_ready` is ignored.
- Halt has priority over redirect. `halt` in FETCH without gnt or in HOLD -> HALT next cycle, buffer discarded. With an outstanding request (WAIT, or FETCH+gnt) set `halt_pend` and `drop`, drain the response, then HALT.
- `pc`+4 wraps modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000).
- `inst`=`NOP_INST` whenever `inst_valid`=0.

## Timing
- Reset values: `imem_req`=0 while `rst_n`=0, `imem_addr`=RESET_PC, `inst`=NOP_INST, `inst_pc`=RESET_PC, `inst_valid`=0, `halted`=0.
- First `imem_req` in the first cycle after `rst_n` deasserts.
- `imem_req`, `imem_addr`, `inst_valid`, `halted` are decoded from registered state only. No combinational path from memory or decode inputs to outputs.
- Minimum latency: gnt in cycle N, rvalid in N+1, `inst_valid` in N+2. Peak throughput is one instruction per 3 cycles.
- At most one outstanding memory request at any time.
- `inst`/`inst_pc` are stable while `inst_valid`=1 and `inst_ready`=0.
- Reset assertion mid-transaction aborts immediately. The in-flight memory response is not tracked after reset; the memory model must drop it on reset.

## Structure
- Add to shared `defines.v`: `RESET_PC`, `NOP_INST`, state encodings `IFU_FETCH/WAIT/HOLD/HALT`, `INST_EBREAK` (32'h0010_0073).
- Single flat module, no sub-module; the buffer is one entry and does not justify a FIFO.

## Test plan
- Reset release, memory grants immediately, rvalid +1 with 0x0010_0093 -> `inst_valid` 2 cycles after req, `inst_pc`=0x8000_0000; next req addr 0x8000_0004.
- `inst_ready`=0 for 5 cycles while valid -> `inst`/`inst_pc` held constant, no new `imem_req`.
- Redirect to 0x8000_0102 in WAIT -> pending response discarded (no `inst_valid`), next req addr 0x8000_0100.
- Redirect in same cycle as gnt -> the one response is dropped, next req at the target address.
- `halt` in WAIT, rvalid 3 cycles later -> no `inst_valid`, `halted`=1 next cycle, no further `imem_req`.
- Redirect to 0xFFFF_FFFC -> fetch there, then the following req is 0x0000_0000.

Source files
------------

// File: rtl/inst_fetch_unit_pkg.sv
// Shared constants and types for the instruction fetch unit.
//   - default reset PC and NOP encoding
//   - fetch FSM state encoding
//   - ebreak encoding (used by execute to raise halt)
package inst_fetch_unit_pkg;

  localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;
  localparam logic [31:0] IFU_NOP_INST = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [31:0] INST_EBREAK  = 32'h0010_0073;

  typedef enum logic [1:0] {
    IFU_FETCH = 2'd0,
    IFU_WAIT  = 2'd1,
    IFU_HOLD  = 2'd2,
    IFU_HALT  = 2'd3
  } ifu_state_e;

  // Redirect targets are forced word-aligned.
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: holds the PC, issues one imem read at a time,
// buffers the returned word and hands it to decode under valid/ready.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   imem_req/addr/gnt          request side of instruction memory
//   imem_rvalid/rdata          response side of instruction memory
//   inst/inst_pc/inst_valid    buffered instruction to decode
//   inst_ready                 decode accepts this cycle
//   redirect/redirect_pc       one-cycle PC redirect from execute
//   halt/halted                ebreak halt pulse / fetch stopped
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IFU_RESET_PC,
  parameter logic [31:0] NOP_INST = IFU_NOP_INST
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        halted
);

  ifu_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_buf_q, inst_buf_d;
  logic [31:0] pc_buf_q, pc_buf_d;
  logic        drop_q, drop_d;
  logic        halt_pend_q, halt_pend_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IFU_FETCH;
      pc_q        <= RESET_PC;
      inst_buf_q  <= NOP_INST;
      pc_buf_q    <= RESET_PC;
      drop_q      <= 1'b0;
      halt_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      inst_buf_q  <= inst_buf_d;
      pc_buf_q    <= pc_buf_d;
      drop_q      <= drop_d;
      halt_pend_q <= halt_pend_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    inst_buf_d  = inst_buf_q;
    pc_buf_d    = pc_buf_q;
    drop_d      = drop_q;
    halt_pend_d = halt_pend_q;
    unique case (state_q)
      IFU_FETCH: begin
        if (halt) begin
          // A granted request must still be drained before stopping.
          if (imem_gnt) begin
            state_d     = IFU_WAIT;
            drop_d      = 1'b1;
            halt_pend_d = 1'b1;
          end else begin
            state_d = IFU_HALT;
          end
        end else begin
          if (redirect) pc_d = word_align(redirect_pc);
          if (imem_gnt) begin
            state_d = IFU_WAIT;
            drop_d  = redirect;  // granted address is now stale
          end
        end
      end
      IFU_WAIT: begin
        if (halt) begin
          drop_d      = 1'b1;
          halt_pend_d = 1'b1;
        end else if (redirect) begin
          pc_d   = word_align(redirect_pc);
          drop_d = 1'b1;
        end
        if (imem_rvalid) begin
          // Same-cycle halt/redirect also discards the arriving word.
          if (drop_q || halt || redirect) begin
            drop_d  = 1'b0;
            state_d = (halt_pend_q || halt) ? IFU_HALT : IFU_FETCH;
          end else begin
            inst_buf_d = imem_rdata;
            pc_buf_d   = pc_q;
            pc_d       = pc_q + 32'd4;  // wraps modulo 2^32
            state_d    = IFU_HOLD;
          end
        end
      end
      IFU_HOLD: begin
        if (halt) begin
          state_d = IFU_HALT;
        end else if (redirect) begin
          pc_d    = word_align(redirect_pc);
          state_d = IFU_FETCH;
        end else if (inst_ready) begin
          state_d = halt_pend_q ? IFU_HALT : IFU_FETCH;
        end
      end
      IFU_HALT: state_d = IFU_HALT;
      default:  state_d = IFU_FETCH;
    endcase
  end

  // Outputs decode registered state only; rst_n gating keeps the request
  // low during reset even though the reset state is FETCH.
  assign imem_req   = rst_n && (state_q == IFU_FETCH);
  assign imem_addr  = pc_q;
  assign inst_valid = (state_q == IFU_HOLD);
  assign inst       = inst_valid ? inst_buf_q : NOP_INST;
  assign inst_pc    = pc_buf_q;
  assign halted     = (state_q == IFU_HALT);

endmodule

// File: tb/tb_inst_fetch_unit.sv
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        halted;

  int pass_cnt = 0;
  int total_cnt = 0;

  inst_fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .redirect(redirect), .redirect_pc(redirect_pc),
    .halt(halt), .halted(halted)
  );

  always #5 clk = ~clk;

  // Advance one cycle; outputs are then sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;
    inst_ready = 0; redirect = 0; redirect_pc = 0; halt = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    #12;
    total_cnt++; if (imem_req !== 1'b0) $display("FAIL rst_req: got %b want 0", imem_req); else pass_cnt++;
    total_cnt++; if (imem_addr !== 32'h8000_0000) $display("FAIL rst_addr: got %h want 80000000", imem_addr); else pass_cnt++;
    total_cnt++; if (inst !== 32'h0000_0013) $display("FAIL rst_inst: got %h want 00000013", inst); else pass_cnt++;
    total_cnt++; if (inst_pc !== 32'h8000_0000) $display("FAIL rst_inst_pc: got %h want 80000000", inst_pc); else pass_cnt++;
    total_cnt++; if (inst_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", inst_valid); else pass_cnt++;
    total_cnt++; if (halted !== 1'b0) $display("FAIL rst_halted: got %b want 0", halted); else pass_cnt++;
    @(posedge clk); #1;
    rst_n = 1;
    #1;
    total_cnt++; if (imem_req !== 1'b1) $display("FAIL first_req: got %b want 1", imem_req); else pass_cnt++;
  endtask

  task automatic test_basic_fetch();
    imem_gnt = 1; tick(); imem_gnt = 0;
    total_cnt++; if (imem_req !== 1'b0) $display("FAIL basic_wait_req: got %b want 0", imem_req); else pass_cnt++;
    imem_rvalid = 1; imem_rdata = 32'h0010_0093; tick(); imem_rvalid = 0;
    total_cnt++; if (inst_valid !== 1'b1) $display("FAIL basic_valid: got %b want 1", inst_valid); else pass_cnt++;
    total_cnt++; if (inst !== 32'h0010_0093) $display("FAIL basic_inst: got %h want 00100093", inst); else pass_cnt++;
    total_cnt++; if (inst_pc !== 32'h8000_0000) $display("FAIL basic_pc: got %h want 80000000", inst_pc); else pass_cnt++;
  endtask

  task automatic test_hold_stall();
    for (int i = 0; i < 5; i++) begin
      tick();
      total_cnt++;
      if (inst_valid !== 1'b1 || inst !== 32'h0010_0093 || inst_pc !== 32'h8000_0000 || imem_req !== 1'b0)
        $display("FAIL hold_stall[%0d]: got v=%b inst=%h pc=%h req=%b want v=1 inst=00100093 pc=80000000 req=0",
                 i, inst_valid, inst, inst_pc, imem_req);
      else pass_cnt++;
    end
    inst_ready = 1; tick(); inst_ready = 0;
    total_cnt++; if (inst_valid !== 1'b0) $display("FAIL accept_valid: got %b want 0", inst_valid); else pass_cnt++;
    total_cnt++; if (inst !== 32'h0000_0013) $display("FAIL accept_nop: got %h want 00000013", inst); else pass_cnt++;
    total_cnt++; if (imem_req !== 1'b1 || imem_addr !== 32'h8000_0004)
      $display("FAIL next_req: got req=%b addr=%h want req=1 addr=80000004", imem_req, imem_addr); else pass_cnt++;
  endtask

  task automatic test_redirect_wait();
    imem_gnt = 1; tick(); imem_gnt = 0;
    redirect = 1; redirect_pc = 32'h8000_0102; tick(); redirect = 0;
    total_cnt++; if (imem_req !== 1'b0 || inst_valid !== 1'b0)
      $display("FAIL rdw_wait: got req=%b v=%b want req=0 v=0", imem_req, inst_valid); else pass_cnt++;
    imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF; tick(); imem_rvalid = 0;
    total_cnt++; if (inst_valid !== 1'b0) $display("FAIL rdw_dropped: got v=%b want 0", inst_valid); else pass_cnt++;
    total_cnt++; if (imem_req !== 1'b1 || imem_addr !== 32'h8000_0100)
      $display("FAIL rdw_target: got req=%b addr=%h want req=1 addr=80000100", imem_req, imem_addr); else pass_cnt++;
  endtask

  task automatic test_redirect_gnt();
    imem_gnt = 1; redirect = 1; redirect_pc = 32'h8000_0200; tick();
    imem_gnt = 0; redirect = 0;
    total_cnt++; if (imem_req !== 1'b0) $display("FAIL rdg_wait: got req=%b want 0", imem_req); else pass_cnt++;
    imem_rvalid = 1; imem_rdata = 32'h1111_1111; tick(); imem_rvalid = 0;
    total_cnt++; if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h8000_0200)
      $display("FAIL rdg_target: got v=%b req=%b addr=%h want v=0 req=1 addr=80000200", inst_valid, imem_req, imem_addr);
    else pass_cnt++;
    imem_gnt = 1; tick(); imem_gnt = 0;
    imem_rvalid = 1; imem_rdata = 32'h0020_0113; tick(); imem_rvalid = 0;
    total_cnt++; if (inst_valid !== 1'b1 || inst !== 32'h0020_0113 || inst_pc !== 32'h8000_0200)
      $display("FAIL rdg_fetch: got v=%b inst=%h pc=%h want v=1 inst=00200113 pc=80000200", inst_valid, inst, inst_pc);
    else pass_cnt++;
  endtask

  task automatic test_redirect_hold();
    // Still holding 0x80000200; redirect wins over simultaneous accept.
    redirect = 1; redirect_pc = 32'h8000_0300; inst_ready = 1; tick();
    redirect = 0; inst_ready = 0;
    total_cnt++; if (inst_valid !== 1'b0 || inst !== 32'h0000_0013)
      $display("FAIL rdh_drop: got v=%b inst=%h want v=0 inst=00000013", inst_valid, inst); else pass_cnt++;
    total_cnt++; if (imem_req !== 1'b1 || imem_addr !== 32'h8000_0300)
      $display("FAIL rdh_target: got req=%b addr=%h want req=1 addr=80000300", imem_req, imem_addr); else pass_cnt++;
  endtask

  task automatic test_wrap();
    redirect = 1; redirect_pc = 32'hFFFF_FFFF; tick(); redirect = 0;
    total_cnt++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC)
      $display("FAIL wrap_target: got req=%b addr=%h want req=1 addr=fffffffc", imem_req, imem_addr); else pass_cnt++;
    imem_gnt = 1; tick(); imem_gnt = 0;
    imem_rvalid = 1; imem_rdata = 32'h0030_0193; tick(); imem_rvalid = 0;
    total_cnt++; if (inst_valid !== 1'b1 || inst_pc !== 32'hFFFF_FFFC)
      $display("FAIL wrap_pc: got v=%b pc=%h want v=1 pc=fffffffc", inst_valid, inst_pc); else pass_cnt++;
    inst_ready = 1; tick(); inst_ready = 0;
    total_cnt++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0000)
      $display("FAIL wrap_next: got req=%b addr=%h want req=1 addr=00000000", imem_req, imem_addr); else pass_cnt++;
  endtask

  task automatic test_halt();
    imem_gnt = 1; tick(); imem_gnt = 0;
    halt = 1; tick(); halt = 0;
    for (int i = 0; i < 2; i++) begin
      total_cnt++; if (imem_req !== 1'b0 || halted !== 1'b0)
        $display("FAIL halt_drain[%0d]: got req=%b halted=%b want req=0 halted=0", i, imem_req, halted); else pass_cnt++;
      tick();
    end
    imem_rvalid = 1; imem_rdata = 32'h0040_0213; tick(); imem_rvalid = 0;
    total_cnt++; if (halted !== 1'b1 || inst_valid !== 1'b0)
      $display("FAIL halt_enter: got halted=%b v=%b want halted=1 v=0", halted, inst_valid); else pass_cnt++;
    redirect = 1; redirect_pc = 32'h8000_0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      total_cnt++; if (imem_req !== 1'b0 || halted !== 1'b1 || inst_valid !== 1'b0)
        $display("FAIL halt_stay[%0d]: got req=%b halted=%b v=%b want req=0 halted=1 v=0", i, imem_req, halted, inst_valid);
      else pass_cnt++;
    end
    redirect = 0;
  endtask

  task automatic test_reset_abort();
    #2 rst_n = 0; #1;
    total_cnt++; if (halted !== 1'b0 || imem_req !== 1'b0 || imem_addr !== 32'h8000_0000)
      $display("FAIL abort: got halted=%b req=%b addr=%h want halted=0 req=0 addr=80000000", halted, imem_req, imem_addr);
    else pass_cnt++;
    tick(); rst_n = 1; #1;
    total_cnt++; if (imem_req !== 1'b1) $display("FAIL abort_restart: got req=%b want 1", imem_req); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_hold_stall();
    test_redirect_wait();
    test_redirect_gnt();
    test_redirect_hold();
    test_wrap();
    test_halt();
    test_reset_abort();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
